// File: rtl/mem_stage.sv
// MEM stage: captures SRAM read data and multiplier product, forms the load/mul/ALU result for WB.
// One-cycle residency minimum; a stalled instruction keeps its captured data until WB accepts it.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es2ms_valid,
  output logic        ms_allowin,
  input  logic [93:0] es2ms_bus,
  input  logic        exe_res_from_mul,
  input  logic [67:0] mul_result,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms2ws_valid,
  output logic [69:0] ms2ws_bus,
  output logic [4:0]  mem_dest,
  output logic        mem_rf_we,
  output logic [31:0] mem_result,
  output logic        ms_is_load
);

  // EXE->MEM bus fields
  logic [31:0] es_pc;
  logic [18:0] es_alu_op;
  logic [31:0] es_alu_result;
  logic [4:0]  es_load_op;
  logic [4:0]  es_dest;
  logic        es_gr_we;

  assign es_pc         = es2ms_bus[93:62];
  assign es_alu_op     = es2ms_bus[61:43];
  assign es_alu_result = es2ms_bus[42:11];
  assign es_load_op    = es2ms_bus[10:6];
  assign es_dest       = es2ms_bus[5:1];
  assign es_gr_we      = es2ms_bus[0];

  // Stage state
  logic        ms_valid_q,     ms_valid_d;
  logic        first_cycle_q,  first_cycle_d;
  logic [31:0] pc_q,           pc_d;
  logic [18:0] alu_op_q,       alu_op_d;
  logic [31:0] alu_result_q,   alu_result_d;
  logic [4:0]  load_op_q,      load_op_d;
  logic [4:0]  dest_q,         dest_d;
  logic        gr_we_q,        gr_we_d;
  logic        res_from_mul_q, res_from_mul_d;
  logic [31:0] rdata_hold_q,   rdata_hold_d;
  logic [63:0] mul_hold_q,     mul_hold_d;

  logic        ms_ready_go;
  logic        accept;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go;
  assign accept      = es2ms_valid & ms_allowin;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    pc_d           = pc_q;
    alu_op_d       = alu_op_q;
    alu_result_d   = alu_result_q;
    load_op_d      = load_op_q;
    dest_d         = dest_q;
    gr_we_d        = gr_we_q;
    res_from_mul_d = res_from_mul_q;
    rdata_hold_d   = rdata_hold_q;
    mul_hold_d     = mul_hold_q;
    // A fresh instruction always starts in its first cycle; otherwise the flag drops.
    first_cycle_d  = accept;

    if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
    end

    if (accept) begin
      pc_d           = es_pc;
      alu_op_d       = es_alu_op;
      alu_result_d   = es_alu_result;
      load_op_d      = es_load_op;
      dest_d         = es_dest;
      gr_we_d        = es_gr_we;
      res_from_mul_d = exe_res_from_mul;
    end

    // Response data is only guaranteed during the first MEM cycle; keep a copy for stalls.
    if (first_cycle_q) begin
      rdata_hold_d = data_sram_rdata;
      mul_hold_d   = mul_result[63:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q     <= 1'b0;
      first_cycle_q  <= 1'b0;
      pc_q           <= 32'd0;
      alu_op_q       <= 19'd0;
      alu_result_q   <= 32'd0;
      load_op_q      <= 5'd0;
      dest_q         <= 5'd0;
      gr_we_q        <= 1'b0;
      res_from_mul_q <= 1'b0;
      rdata_hold_q   <= 32'd0;
      mul_hold_q     <= 64'd0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      first_cycle_q  <= first_cycle_d;
      pc_q           <= pc_d;
      alu_op_q       <= alu_op_d;
      alu_result_q   <= alu_result_d;
      load_op_q      <= load_op_d;
      dest_q         <= dest_d;
      gr_we_q        <= gr_we_d;
      res_from_mul_q <= res_from_mul_d;
      rdata_hold_q   <= rdata_hold_d;
      mul_hold_q     <= mul_hold_d;
    end
  end

  // Effective data: live bus in the first cycle, captured copy afterwards
  logic [31:0] rdata_eff;
  logic [63:0] mul_eff;

  assign rdata_eff = first_cycle_q ? data_sram_rdata   : rdata_hold_q;
  assign mul_eff   = first_cycle_q ? mul_result[63:0]  : mul_hold_q;

  // Load byte/half extraction
  logic [1:0]  addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign addr = alu_result_q[1:0];

  always_comb begin
    load_byte = rdata_eff[7:0];
    case (addr)
      2'd0: load_byte = rdata_eff[7:0];
      2'd1: load_byte = rdata_eff[15:8];
      2'd2: load_byte = rdata_eff[23:16];
      2'd3: load_byte = rdata_eff[31:24];
      default: load_byte = rdata_eff[7:0];
    endcase
  end

  assign load_half = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_data = rdata_eff;
    if (load_op_q[0]) begin
      load_data = {{24{load_byte[7]}}, load_byte};
    end else if (load_op_q[1]) begin
      load_data = {24'd0, load_byte};
    end else if (load_op_q[2]) begin
      load_data = {{16{load_half[15]}}, load_half};
    end else if (load_op_q[3]) begin
      load_data = {16'd0, load_half};
    end else if (load_op_q[4]) begin
      load_data = rdata_eff;
    end
  end

  // Multiplier selection: high word for mulh.w / mulh.wu, low word otherwise
  logic [31:0] mul_data;

  always_comb begin
    mul_data = mul_eff[31:0];
    if (alu_op_q[12]) begin
      mul_data = mul_eff[31:0];
    end else if (alu_op_q[13] | alu_op_q[14]) begin
      mul_data = mul_eff[63:32];
    end
  end

  logic        is_load;
  logic [31:0] final_result;

  assign is_load = |load_op_q;

  always_comb begin
    final_result = alu_result_q;
    if (is_load) begin
      final_result = load_data;
    end else if (res_from_mul_q) begin
      final_result = mul_data;
    end
  end

  assign ms2ws_bus  = {pc_q, dest_q, final_result, gr_we_q};
  assign mem_dest   = dest_q;
  assign mem_rf_we  = ms_valid_q & gr_we_q;
  assign mem_result = final_result;
  assign ms_is_load = ms_valid_q & is_load;

  // Opcode bits not consumed here and the multiplier's guard bits
  logic unused_bits;
  assign unused_bits = ^{alu_op_q[18:15], alu_op_q[11:0], mul_result[67:64]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, multiplier select, stall hold, back-to-back, reset.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic [93:0] es2ms_bus;
  logic        exe_res_from_mul;
  logic [67:0] mul_result;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [69:0] ms2ws_bus;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] mem_result;
  logic        ms_is_load;

  int checks;
  int failures;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .es2ms_valid      (es2ms_valid),
    .ms_allowin       (ms_allowin),
    .es2ms_bus        (es2ms_bus),
    .exe_res_from_mul (exe_res_from_mul),
    .mul_result       (mul_result),
    .data_sram_rdata  (data_sram_rdata),
    .ws_allowin       (ws_allowin),
    .ms2ws_valid      (ms2ws_valid),
    .ms2ws_bus        (ms2ws_bus),
    .mem_dest         (mem_dest),
    .mem_rf_we        (mem_rf_we),
    .mem_result       (mem_result),
    .ms_is_load       (ms_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [93:0] mk_bus(input logic [31:0] pc, input logic [18:0] alu_op,
                                         input logic [31:0] alu_res, input logic [4:0] load_op,
                                         input logic [4:0] dest, input logic gr_we);
    return {pc, alu_op, alu_res, load_op, dest, gr_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    es2ms_valid      = 1'b0;
    exe_res_from_mul = 1'b0;
    ws_allowin       = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL reset_ms2ws_valid got=%0b exp=0", ms2ws_valid); end
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_ms_allowin got=%0b exp=1", ms_allowin); end
    checks++; if (ms2ws_bus !== 70'd0) begin failures++; $display("FAIL reset_ms2ws_bus got=%h exp=0", ms2ws_bus); end
    checks++; if (mem_dest !== 5'd0) begin failures++; $display("FAIL reset_mem_dest got=%h exp=0", mem_dest); end
    checks++; if (mem_result !== 32'd0) begin failures++; $display("FAIL reset_mem_result got=%h exp=0", mem_result); end
    checks++; if (mem_rf_we !== 1'b0) begin failures++; $display("FAIL reset_mem_rf_we got=%0b exp=0", mem_rf_we); end
    checks++; if (ms_is_load !== 1'b0) begin failures++; $display("FAIL reset_ms_is_load got=%0b exp=0", ms_is_load); end
  endtask

  task automatic test_load();
    logic [4:0]  lop;
    logic [31:0] addr;
    logic [31:0] exp;
    ws_allowin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin lop = 5'b00001; addr = 32'h1003; exp = 32'hFFFFFF80; end
        1: begin lop = 5'b00010; addr = 32'h1003; exp = 32'h00000080; end
        2: begin lop = 5'b00100; addr = 32'h1002; exp = 32'hFFFF80FF; end
        3: begin lop = 5'b01000; addr = 32'h1000; exp = 32'h00007F01; end
        default: begin lop = 5'b10000; addr = 32'h1000; exp = 32'h80FF7F01; end
      endcase
      es2ms_valid     = 1'b1;
      es2ms_bus       = mk_bus(32'h1C00_0100 + 32'(i * 4), 19'd0, addr, lop, 5'(i + 3), 1'b1);
      data_sram_rdata = 32'h0;
      tick();
      es2ms_valid     = 1'b0;
      data_sram_rdata = 32'h80FF7F01;
      #1;
      checks++; if (mem_result !== exp) begin failures++; $display("FAIL load%0d_mem_result got=%h exp=%h", i, mem_result, exp); end
      checks++; if (ms2ws_bus[32:1] !== exp) begin failures++; $display("FAIL load%0d_bus_result got=%h exp=%h", i, ms2ws_bus[32:1], exp); end
      checks++; if (ms_is_load !== 1'b1) begin failures++; $display("FAIL load%0d_ms_is_load got=%0b exp=1", i, ms_is_load); end
      checks++; if (mem_dest !== 5'(i + 3)) begin failures++; $display("FAIL load%0d_mem_dest got=%0d exp=%0d", i, mem_dest, i + 3); end
      checks++; if (ms2ws_valid !== 1'b1) begin failures++; $display("FAIL load%0d_ms2ws_valid got=%0b exp=1", i, ms2ws_valid); end
    end
    tick();
    checks++; if (ms_is_load !== 1'b0) begin failures++; $display("FAIL load_retire_ms_is_load got=%0b exp=0", ms_is_load); end
  endtask

  task automatic test_mul();
    logic [18:0] op;
    logic [31:0] exp;
    ws_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin op = 19'd1 << 14; exp = 32'h12345678; end
        1: begin op = 19'd1 << 12; exp = 32'h9ABCDEF0; end
        default: begin op = 19'd1 << 13; exp = 32'h12345678; end
      endcase
      es2ms_valid      = 1'b1;
      exe_res_from_mul = 1'b1;
      es2ms_bus        = mk_bus(32'h1C00_0200 + 32'(i * 4), op, 32'h5555_AAAA, 5'd0, 5'd9, 1'b1);
      mul_result       = 68'h0;
      tick();
      es2ms_valid      = 1'b0;
      exe_res_from_mul = 1'b0;
      mul_result       = 68'hF_12345678_9ABCDEF0;
      #1;
      checks++; if (mem_result !== exp) begin failures++; $display("FAIL mul%0d_mem_result got=%h exp=%h", i, mem_result, exp); end
      checks++; if (ms_is_load !== 1'b0) begin failures++; $display("FAIL mul%0d_ms_is_load got=%0b exp=0", i, ms_is_load); end
    end
    tick();
  endtask

  task automatic test_stall();
    drain();
    es2ms_valid     = 1'b1;
    es2ms_bus       = mk_bus(32'h1C00_0300, 19'd0, 32'h2000, 5'b10000, 5'd7, 1'b1);
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h0;
    tick();
    // A different instruction keeps knocking; it must not be taken while stalled.
    es2ms_bus       = mk_bus(32'h1C00_0400, 19'd0, 32'h1234, 5'd0, 5'd8, 1'b1);
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (mem_result !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_first_result got=%h exp=deadbeef", mem_result); end
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'h0;
      #1;
      checks++; if (mem_result !== 32'hDEADBEEF) begin failures++; $display("FAIL stall%0d_result got=%h exp=deadbeef", c, mem_result); end
      checks++; if (ms_allowin !== 1'b0) begin failures++; $display("FAIL stall%0d_allowin got=%0b exp=0", c, ms_allowin); end
      checks++; if (ms2ws_bus[69:38] !== 32'h1C00_0300) begin failures++; $display("FAIL stall%0d_pc got=%h exp=1c000300", c, ms2ws_bus[69:38]); end
      checks++; if (ms2ws_valid !== 1'b1) begin failures++; $display("FAIL stall%0d_valid got=%0b exp=1", c, ms2ws_valid); end
    end
    es2ms_valid = 1'b0;
    ws_allowin  = 1'b1;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL stall_release_allowin got=%0b exp=1", ms_allowin); end
    tick();
    checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL stall_retired_valid got=%0b exp=0", ms2ws_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic        we;
    drain();
    for (int i = 0; i < 3; i++) begin
      res = 32'hA000_0000 + 32'(i * 17);
      we  = (i != 1);
      es2ms_valid = 1'b1;
      es2ms_bus   = mk_bus(32'h1C00_0500 + 32'(i * 4), 19'd1, res, 5'd0, 5'(i + 20), we);
      tick();
      checks++; if (ms2ws_valid !== 1'b1) begin failures++; $display("FAIL b2b%0d_valid got=%0b exp=1", i, ms2ws_valid); end
      checks++; if (ms2ws_bus !== {32'h1C00_0500 + 32'(i * 4), 5'(i + 20), res, we}) begin
        failures++; $display("FAIL b2b%0d_bus got=%h exp=%h", i, ms2ws_bus, {32'h1C00_0500 + 32'(i * 4), 5'(i + 20), res, we});
      end
      checks++; if (mem_rf_we !== we) begin failures++; $display("FAIL b2b%0d_rf_we got=%0b exp=%0b", i, mem_rf_we, we); end
      checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL b2b%0d_allowin got=%0b exp=1", i, ms_allowin); end
    end
    es2ms_valid = 1'b0;
    tick();
    checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain_valid got=%0b exp=0", ms2ws_valid); end
  endtask

  task automatic test_reset_mid();
    drain();
    es2ms_valid     = 1'b1;
    es2ms_bus       = mk_bus(32'h1C00_0600, 19'd0, 32'h3001, 5'b00001, 5'd11, 1'b1);
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1111_2222;
    tick();
    #1;
    checks++; if (ms_is_load !== 1'b1) begin failures++; $display("FAIL rmid_pre_is_load got=%0b exp=1", ms_is_load); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    es2ms_valid = 1'b0;
    #1;
    checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", ms2ws_valid); end
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL rmid_allowin got=%0b exp=1", ms_allowin); end
    checks++; if (ms_is_load !== 1'b0) begin failures++; $display("FAIL rmid_is_load got=%0b exp=0", ms_is_load); end
    checks++; if (ms2ws_bus !== 70'd0) begin failures++; $display("FAIL rmid_bus got=%h exp=0", ms2ws_bus); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    es2ms_valid      = 1'b0;
    es2ms_bus        = 94'd0;
    exe_res_from_mul = 1'b0;
    mul_result       = 68'd0;
    data_sram_rdata  = 32'd0;
    ws_allowin       = 1'b1;
    test_reset();
    test_load();
    test_mul();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
